pic_exec_core: RTL and testbench

- Execution core of the PIC16F84-style processor.
- Contains three functions:
  - a four-phase clock generator (Q1..Q4 strobes that sequence PC, instruction fetch, ALU and register write-back);
  - a combinational opcode decoder;
  - the 8-bit ALU with STATUS flags Z/C/DC and a skip indication.
- Sits between the instruction register/operand mux and the W/file registers.

---
 rtl/pic_pkg.sv | 66 ++++++
 rtl/pic_phase_gen.sv | 32 +++
 rtl/pic_exec_core.sv | 224 ++++++++++++++++++++++
 tb/tb_pic_exec_core.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants for the PIC16F84-style execution core.
// Covers the instruction classes, the opcode nibbles, and the add/subtract flag helper.
package pic_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned PHASE_BITS = 2;

  typedef enum logic [1:0] {
    TYPE_BYTE = 2'b00,
    TYPE_BIT  = 2'b01,
    TYPE_CTRL = 2'b10,
    TYPE_LIT  = 2'b11
  } op_type_e;

  // Byte-oriented operations
  localparam logic [3:0] OP_MOVWF  = 4'h0;
  localparam logic [3:0] OP_CLR    = 4'h1;
  localparam logic [3:0] OP_SUBWF  = 4'h2;
  localparam logic [3:0] OP_DECF   = 4'h3;
  localparam logic [3:0] OP_IORWF  = 4'h4;
  localparam logic [3:0] OP_ANDWF  = 4'h5;
  localparam logic [3:0] OP_XORWF  = 4'h6;
  localparam logic [3:0] OP_ADDWF  = 4'h7;
  localparam logic [3:0] OP_MOVF   = 4'h8;
  localparam logic [3:0] OP_COMF   = 4'h9;
  localparam logic [3:0] OP_INCF   = 4'hA;
  localparam logic [3:0] OP_DECFSZ = 4'hB;
  localparam logic [3:0] OP_RRF    = 4'hC;
  localparam logic [3:0] OP_RLF    = 4'hD;
  localparam logic [3:0] OP_SWAPF  = 4'hE;
  localparam logic [3:0] OP_INCFSZ = 4'hF;

  // Bit-oriented operations, selected by opcode[3:2]
  localparam logic [1:0] BOP_BCF   = 2'b00;
  localparam logic [1:0] BOP_BSF   = 2'b01;
  localparam logic [1:0] BOP_BTFSC = 2'b10;
  localparam logic [1:0] BOP_BTFSS = 2'b11;

  // Literal operations with a full nibble encoding
  localparam logic [3:0] OP_IORLW = 4'h8;
  localparam logic [3:0] OP_ANDLW = 4'h9;
  localparam logic [3:0] OP_XORLW = 4'hA;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             dc;
  } add_res_t;

  // Subtraction a - b is add_with_flags(a, ~b, 1): c and dc then read as "no borrow".
  function automatic add_res_t add_with_flags(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             cin);
    logic [WIDTH:0] full;
    logic [4:0]     nib;
    add_res_t       r;
    full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    nib   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    r.sum = full[WIDTH-1:0];
    r.c   = full[WIDTH];
    r.dc  = nib[4];
    return r;
  endfunction

endpackage

// File: rtl/pic_phase_gen.sv
// Four-phase strobe generator: a rotating one-hot Q1..Q4 strobe, one master clock per phase.
// strobe_o[0] is Q1, strobe_o[3] is Q4.
module pic_phase_gen
  import pic_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [NUM_PHASES-1:0] strobe_o
);

  logic [PHASE_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_PHASES-1:0] strobe_q, strobe_d;

  // The counter leads the strobe by one edge, so the first edge out of reset raises Q1.
  always_comb begin
    cnt_d    = cnt_q + PHASE_BITS'(1);
    strobe_d = NUM_PHASES'(1) << cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      strobe_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/pic_exec_core.sv
// PIC16F84-style execution core: phase strobes, opcode decode, and the 8-bit ALU.
// Results and the Z/C/DC/skip flags are registered on the Q3 (clk_alu) phase.
module pic_exec_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             master_clk,
  input  logic             reset,
  input  logic [5:0]       full_opcode,
  input  logic             enable_instr_reg,
  input  logic [WIDTH-1:0] w_in,
  input  logic [WIDTH-1:0] alu_in,
  output logic             clk_pc,
  output logic             clk_instruction_memory,
  output logic             clk_alu,
  output logic             clk_registers,
  output logic [1:0]       type_opcode,
  output logic [3:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             status_z,
  output logic             status_c,
  output logic             status_dc,
  output logic             skip
);
  import pic_pkg::*;

  logic [NUM_PHASES-1:0] phase;

  pic_phase_gen u_phase_gen (
    .clk_i    (master_clk),
    .rst_i    (reset),
    .strobe_o (phase)
  );

  assign clk_pc                 = phase[0];
  assign clk_instruction_memory = phase[1];
  assign clk_alu                = phase[2];
  assign clk_registers          = phase[3];

  op_type_e   op_type;
  logic [3:0] op;

  assign type_opcode = full_opcode[5:4];
  assign opcode      = full_opcode[3:0];
  assign op_type     = op_type_e'(full_opcode[5:4]);
  assign op          = full_opcode[3:0];

  add_res_t         add_fw, sub_fw;
  logic [WIDTH-1:0] inc_f, dec_f;
  logic [2:0]       bit_idx;
  logic [WIDTH-1:0] bit_mask;
  logic             bit_val;

  assign add_fw   = add_with_flags(alu_in, w_in, 1'b0);
  assign sub_fw   = add_with_flags(alu_in, ~w_in, 1'b1);
  assign inc_f    = alu_in + WIDTH'(1);
  assign dec_f    = alu_in - WIDTH'(1);
  assign bit_idx  = {op[1:0], enable_instr_reg};
  assign bit_mask = WIDTH'(1) << bit_idx;
  assign bit_val  = alu_in[bit_idx];

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             z_q, z_d, c_q, c_d, dc_q, dc_d, skip_q, skip_d;
  logic             load, set_z;

  always_comb begin
    alu_out_d = alu_out_q;
    z_d       = z_q;
    c_d       = c_q;
    dc_d      = dc_q;
    skip_d    = 1'b0;
    load      = 1'b1;
    set_z     = 1'b0;

    unique case (op_type)
      TYPE_BYTE: begin
        unique case (op)
          OP_MOVWF: begin
            // d = 0 is NOP: nothing loads, including skip.
            if (enable_instr_reg) begin
              alu_out_d = w_in;
              set_z     = 1'b1;
            end else begin
              load = 1'b0;
            end
          end
          OP_CLR: begin
            alu_out_d = '0;
            set_z     = 1'b1;
          end
          OP_SUBWF: begin
            alu_out_d = sub_fw.sum;
            c_d       = sub_fw.c;
            dc_d      = sub_fw.dc;
            set_z     = 1'b1;
          end
          OP_DECF: begin
            alu_out_d = dec_f;
            set_z     = 1'b1;
          end
          OP_IORWF: begin
            alu_out_d = alu_in | w_in;
            set_z     = 1'b1;
          end
          OP_ANDWF: begin
            alu_out_d = alu_in & w_in;
            set_z     = 1'b1;
          end
          OP_XORWF: begin
            alu_out_d = alu_in ^ w_in;
            set_z     = 1'b1;
          end
          OP_ADDWF: begin
            alu_out_d = add_fw.sum;
            c_d       = add_fw.c;
            dc_d      = add_fw.dc;
            set_z     = 1'b1;
          end
          OP_MOVF: begin
            alu_out_d = alu_in;
            set_z     = 1'b1;
          end
          OP_COMF: begin
            alu_out_d = ~alu_in;
            set_z     = 1'b1;
          end
          OP_INCF: begin
            alu_out_d = inc_f;
            set_z     = 1'b1;
          end
          OP_DECFSZ: begin
            alu_out_d = dec_f;
            skip_d    = (dec_f == '0);
          end
          OP_RRF: begin
            alu_out_d = {c_q, alu_in[WIDTH-1:1]};
            c_d       = alu_in[0];
          end
          OP_RLF: begin
            alu_out_d = {alu_in[WIDTH-2:0], c_q};
            c_d       = alu_in[WIDTH-1];
          end
          OP_SWAPF: alu_out_d = {alu_in[3:0], alu_in[7:4]};
          OP_INCFSZ: begin
            alu_out_d = inc_f;
            skip_d    = (inc_f == '0);
          end
        endcase
      end
      TYPE_BIT: begin
        unique case (op[3:2])
          BOP_BCF:   alu_out_d = alu_in & ~bit_mask;
          BOP_BSF:   alu_out_d = alu_in | bit_mask;
          BOP_BTFSC: begin
            alu_out_d = alu_in;
            skip_d    = ~bit_val;
          end
          BOP_BTFSS: begin
            alu_out_d = alu_in;
            skip_d    = bit_val;
          end
        endcase
      end
      TYPE_CTRL: ;
      TYPE_LIT: begin
        unique casez (op)
          4'b00??, 4'b01??: alu_out_d = alu_in;
          OP_IORLW: begin
            alu_out_d = alu_in | w_in;
            set_z     = 1'b1;
          end
          OP_ANDLW: begin
            alu_out_d = alu_in & w_in;
            set_z     = 1'b1;
          end
          OP_XORLW: begin
            alu_out_d = alu_in ^ w_in;
            set_z     = 1'b1;
          end
          // Unassigned encoding behaves as a plain literal move.
          4'b1011: alu_out_d = alu_in;
          4'b110?: begin
            alu_out_d = sub_fw.sum;
            c_d       = sub_fw.c;
            dc_d      = sub_fw.dc;
            set_z     = 1'b1;
          end
          4'b111?: begin
            alu_out_d = add_fw.sum;
            c_d       = add_fw.c;
            dc_d      = add_fw.dc;
            set_z     = 1'b1;
          end
        endcase
      end
    endcase

    if (set_z) begin
      z_d = (alu_out_d == '0);
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      alu_out_q <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      dc_q      <= 1'b0;
      skip_q    <= 1'b0;
    end else if (clk_alu && load) begin
      alu_out_q <= alu_out_d;
      z_q       <= z_d;
      c_q       <= c_d;
      dc_q      <= dc_d;
      skip_q    <= skip_d;
    end
  end

  assign alu_out   = alu_out_q;
  assign status_z  = z_q;
  assign status_c  = c_q;
  assign status_dc = dc_q;
  assign skip      = skip_q;

endmodule

// File: tb/tb_pic_exec_core.sv
// Self-checking bench for pic_exec_core: a directed vector table, hand-written phase sequences,
// and random instructions compared against an arithmetic reference model.
module tb_pic_exec_core;

  logic       master_clk = 1'b0;
  logic       reset;
  logic [5:0] full_opcode;
  logic       enable_instr_reg;
  logic [7:0] w_in, alu_in;
  logic       clk_pc, clk_instruction_memory, clk_alu, clk_registers;
  logic [1:0] type_opcode;
  logic [3:0] opcode;
  logic [7:0] alu_out;
  logic       status_z, status_c, status_dc, skip;
  logic [3:0] strobes;

  pic_exec_core #(.WIDTH(8)) dut (
    .master_clk             (master_clk),
    .reset                  (reset),
    .full_opcode            (full_opcode),
    .enable_instr_reg       (enable_instr_reg),
    .w_in                   (w_in),
    .alu_in                 (alu_in),
    .clk_pc                 (clk_pc),
    .clk_instruction_memory (clk_instruction_memory),
    .clk_alu                (clk_alu),
    .clk_registers          (clk_registers),
    .type_opcode            (type_opcode),
    .opcode                 (opcode),
    .alu_out                (alu_out),
    .status_z               (status_z),
    .status_c               (status_c),
    .status_dc              (status_dc),
    .skip                   (skip)
  );

  always #5 master_clk = ~master_clk;
  assign strobes = {clk_registers, clk_alu, clk_instruction_memory, clk_pc};

  int checks = 0;
  int errors = 0;

  // Reference architectural state
  logic [7:0] m_res;
  logic       m_z, m_c, m_dc, m_skip;

  typedef struct {
    string      name;
    logic [5:0] fo;
    logic       d;
    logic [7:0] w;
    logic [7:0] f;
    logic [7:0] res;
    logic       z, c, dc, skp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_res  = 8'h00;
    m_z    = 1'b0;
    m_c    = 1'b0;
    m_dc   = 1'b0;
    m_skip = 1'b0;
  endtask

  // Instruction semantics written directly with integer arithmetic.
  task automatic model_op(input logic [5:0] fo, input logic d, input logic [7:0] w8,
                          input logic [7:0] f8);
    int f, w, r, cls, op, b, bv;
    bit setz;
    f    = int'(f8);
    w    = int'(w8);
    cls  = int'(fo[5:4]);
    op   = int'(fo[3:0]);
    r    = int'(m_res);
    setz = 1'b0;
    if (cls == 0 && op == 0 && !d) return;
    m_skip = 1'b0;
    case (cls)
      0: begin
        setz = 1'b1;
        case (op)
          0: r = w;
          1: r = 0;
          2: begin
            r = (f - w + 256) % 256;
            m_c = (f >= w);
            m_dc = ((f % 16) >= (w % 16));
          end
          3: r = (f + 255) % 256;
          4: r = f | w;
          5: r = f & w;
          6: r = f ^ w;
          7: begin
            r = (f + w) % 256;
            m_c = ((f + w) > 255);
            m_dc = ((f % 16 + w % 16) > 15);
          end
          8: r = f;
          9: r = 255 - f;
          10: r = (f + 1) % 256;
          11: begin
            r = (f + 255) % 256;
            m_skip = (r == 0);
            setz = 1'b0;
          end
          12: begin
            r = f / 2 + (m_c ? 128 : 0);
            m_c = (f % 2 == 1);
            setz = 1'b0;
          end
          13: begin
            r = (f * 2) % 256 + (m_c ? 1 : 0);
            m_c = (f >= 128);
            setz = 1'b0;
          end
          14: begin
            r = (f % 16) * 16 + f / 16;
            setz = 1'b0;
          end
          default: begin
            r = (f + 1) % 256;
            m_skip = (r == 0);
            setz = 1'b0;
          end
        endcase
      end
      1: begin
        b  = (op % 4) * 2 + (d ? 1 : 0);
        bv = (f >> b) % 2;
        case (op / 4)
          0: r = (bv == 1) ? f - (1 << b) : f;
          1: r = (bv == 1) ? f : f + (1 << b);
          2: begin
            r = f;
            m_skip = (bv == 0);
          end
          default: begin
            r = f;
            m_skip = (bv == 1);
          end
        endcase
      end
      2: ;
      default: begin
        if (op < 8 || op == 11) r = f;
        else if (op == 8) begin r = f | w; setz = 1'b1; end
        else if (op == 9) begin r = f & w; setz = 1'b1; end
        else if (op == 10) begin r = f ^ w; setz = 1'b1; end
        else if (op < 14) begin
          r = (f - w + 256) % 256;
          m_c = (f >= w);
          m_dc = ((f % 16) >= (w % 16));
          setz = 1'b1;
        end else begin
          r = (f + w) % 256;
          m_c = ((f + w) > 255);
          m_dc = ((f % 16 + w % 16) > 15);
          setz = 1'b1;
        end
      end
    endcase
    m_res = 8'(r);
    if (setz) m_z = (r == 0);
  endtask

  // Waits for the Q3 cycle (scrambling operands and checking the hold meanwhile), then
  // presents the instruction so it is captured on that clk_alu edge.
  task automatic run_op(input logic [5:0] fo, input logic d, input logic [7:0] w,
                        input logic [7:0] f);
    int guard = 0;
    @(negedge master_clk);
    while (clk_alu !== 1'b1 && guard < 8) begin
      full_opcode      = 6'($urandom);
      enable_instr_reg = 1'($urandom);
      w_in             = 8'($urandom);
      alu_in           = 8'($urandom);
      chk("hold_alu_out", 32'(alu_out), 32'(m_res));
      chk("hold_flags", {29'd0, status_z, status_c, skip}, {29'd0, m_z, m_c, m_skip});
      guard++;
      @(negedge master_clk);
    end
    if (guard >= 8) begin
      checks++;
      errors++;
      $display("FAIL alu_phase_timeout: got no clk_alu, expected clk_alu within 8 cycles");
    end
    full_opcode      = fo;
    enable_instr_reg = d;
    w_in             = w;
    alu_in           = f;
    #1;
    chk("type_opcode", 32'(type_opcode), 32'(fo[5:4]));
    chk("opcode", 32'(opcode), 32'(fo[3:0]));
    model_op(fo, d, w, f);
    @(posedge master_clk);
    #1;
  endtask

  task automatic cmp_out(input string name, input logic [7:0] res, input logic z, input logic c,
                         input logic dc, input logic skp);
    chk({name, "_alu_out"}, 32'(alu_out), 32'(res));
    chk({name, "_z"}, 32'(status_z), 32'(z));
    chk({name, "_c"}, 32'(status_c), 32'(c));
    chk({name, "_dc"}, 32'(status_dc), 32'(dc));
    chk({name, "_skip"}, 32'(skip), 32'(skp));
  endtask

  initial begin
    logic [5:0] rfo;
    int         guard;

    vecs[0]  = '{"addwf",  6'b000111, 1'b1, 8'h8F, 8'h71, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"sublw",  6'b111100, 1'b0, 8'h06, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"addlw",  6'b111110, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{"rrf",    6'b001100, 1'b1, 8'h00, 8'h02, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"rlf",    6'b001101, 1'b1, 8'h00, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{"movf",   6'b001000, 1'b1, 8'h00, 8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{"decfsz", 6'b001011, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{"btfss",  6'b011101, 1'b1, 8'h00, 8'h08, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{"nop",    6'b000000, 1'b0, 8'h55, 8'hAA, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{"bsf",    6'b010110, 1'b0, 8'h00, 8'h00, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{"btfsc",  6'b011000, 1'b1, 8'h00, 8'hFD, 8'hFD, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{"goto",   6'b101010, 1'b0, 8'h33, 8'h44, 8'hFD, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{"bcf",    6'b010011, 1'b1, 8'h00, 8'hFF, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{"subwf",  6'b000010, 1'b1, 8'h01, 8'h10, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{"clrf",   6'b000001, 1'b1, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{"movwf",  6'b000000, 1'b1, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{"xorlw",  6'b111010, 1'b0, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{"incfsz", 6'b001111, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

    reset            = 1'b1;
    full_opcode      = 6'b000000;
    enable_instr_reg = 1'b0;
    w_in             = 8'h00;
    alu_in           = 8'h00;
    model_reset();

    // Reset held six cycles: strobes and ALU state all clear.
    for (int i = 0; i < 6; i++) begin
      @(negedge master_clk);
      chk("reset_strobes", 32'(strobes), 32'h0);
      cmp_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge master_clk);
      chk($sformatf("rotate_%0d", i), 32'(strobes), 32'(4'b0001 << (i % 4)));
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].fo, vecs[i].d, vecs[i].w, vecs[i].f);
      cmp_out(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].dc, vecs[i].skp);
    end

    // ADDWF operands that would change everything, presented outside Q3 only.
    for (int i = 0; i < 3; i++) begin
      @(negedge master_clk);
      if (clk_alu !== 1'b1) begin
        full_opcode      = 6'b000111;
        enable_instr_reg = 1'b1;
        w_in             = 8'h81;
        alu_in           = 8'h7F;
      end else begin
        full_opcode      = 6'b000000;
        enable_instr_reg = 1'b0;
      end
      @(posedge master_clk);
      #1;
      cmp_out("hold_q", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    for (int n = 0; n < 400; n++) begin
      rfo = 6'($urandom);
      if (rfo == 6'b111011) rfo = 6'b111010;
      run_op(rfo, 1'($urandom), 8'($urandom), 8'($urandom));
      cmp_out($sformatf("rand_%0d_op%02h", n, rfo), m_res, m_z, m_c, m_dc, m_skip);
    end

    // Reset landing mid-rotation (during Q2) clears strobes and ALU state on the next edge.
    guard = 0;
    @(negedge master_clk);
    while (clk_instruction_memory !== 1'b1 && guard < 8) begin
      guard++;
      @(negedge master_clk);
    end
    if (guard >= 8) begin
      checks++;
      errors++;
      $display("FAIL q2_timeout: got no clk_instruction_memory, expected it within 8 cycles");
    end
    reset = 1'b1;
    @(negedge master_clk);
    chk("midreset_strobes", 32'(strobes), 32'h0);
    cmp_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge master_clk);
    reset = 1'b0;
    model_reset();
    @(negedge master_clk);
    chk("post_reset_q1", 32'(strobes), 32'b0001);
    run_op(6'b000111, 1'b1, 8'h08, 8'h08);
    cmp_out("post_reset_addwf", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
